reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register scoreboard that tracks integer destination registers with outstanding variable-latency writes: loads that see memory wait states, and vector-to-scalar moves from the vector core. It is the issue/retire bookkeeping counterpart of the fixed-latency load-use stall logic. It sits beside the ID stage and drives the same stall outputs (ifid_write, pcwrite, hazard bubble), merged by AND/OR in the core top. Issue records a pending write; completion from the writeback side clears it.

## Interface
- MAX_OUTSTANDING, 4: maximum long-latency writes in flight (1..31).
- NREG, 32: architectural integer registers; x0 is never tracked.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- rs1_id, rs2_id  in  5  source indices of ID instruction.
- use_rs1, use_rs2  in  1  corresponding source is actually read.
- rd_id  in  5  destination index of ID instruction.
- long_lat_id  in  1  ID instruction is a variable-latency writer.
- fence_id  in  1  ID instruction must wait until nothing is outstanding.
- flush  in  1  branch/redirect squashes the ID instruction this cycle.
- cpl_valid  in  1  a long-latency write completes this cycle.
- cpl_rd  in  5  register written by the completion.
- ifid_write  out  1  0 = hold IF/ID register.
- pcwrite  out  1  0 = hold PC.
- hazard  out  1  1 = insert bubble into ID/EX.
- pending  out  NREG  registered pending-write bit vector.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  registered in-flight count.
- cpl_err  out  1  sticky: completion arrived for a non-pending register.

## Operation
- Effective pending (eff) = pending with bit cpl_rd cleared when cpl_valid (completion bypass). All stall checks use eff.
- stall = id_valid & !flush & (raw | waw | full | fence_wait).
  - raw: (use_rs1 & rs1_id≠0 & eff[rs1_id]) | (use_rs2 & rs2_id≠0 & eff[rs2_id]).
  - waw: rd_id≠0 & eff[rd_id] (any writer type).
  - full: long_lat_id & rd_id≠0 & outstanding==MAX_OUTSTANDING & !cpl_valid.
  - fence_wait: fence_id & (outstanding − cpl_valid) ≠ 0.
- Outputs: hazard = stall; ifid_write = pcwrite = !stall.
- issue = id_valid & !flush & !stall & long_lat_id & rd_id≠0.
- Next pending: set bit rd_id on issue; clear bit cpl_rd on cpl_valid with cpl_rd≠0; set wins if same index (only reachable via bypass).
- Next outstanding: +1 on issue only, −1 on valid tracked completion only, unchanged on both.
- Completion with cpl_rd=0: ignored, no count change, no error.
- Completion to non-pending register (cpl_rd≠0): no state change, cpl_err set until reset.
- Invariant: outstanding == popcount(pending); assertion in bench.

## Timing
- Reset (rst_n low, asynchronous): pending=0, outstanding=0, cpl_err=0; with empty state ifid_write=1, pcwrite=1, hazard=0.
- Stall outputs are combinational from registered state and same-cycle inputs; zero-cycle latency.
- Issue in cycle N: pending bit visible in cycle N+1. A dependent instruction stalls from N+1.
- Completion in cycle N releases a dependent stall in cycle N via bypass; state clears at edge ending N.
- Flush overrides stall and issue in the same cycle; nothing is recorded for the squashed instruction.
- Reset mid-operation discards all in-flight tracking. Late completions after reset raise cpl_err, which is expected and tolerated by the core.

## Structure
- Shared package core_pkg: NREG, reg_idx_t (5-bit), MAX_OUTSTANDING default, count-width constant.
- One sub-module, sb_decode: 5-to-32 one-hot decoder with x0 masked. It is instantiated for rd_id set and cpl_rd clear masks.
- Remaining logic (eff, stall, counter) stays flat in reg_scoreboard.

## Test plan
- Reset then idle: ifid_write=1, pcwrite=1, hazard=0, pending=0, outstanding=0.
- RAW: issue load to x5 at cycle 0; ID uses rs1=x5 at cycle 1 → hazard=1 until cpl_valid,cpl_rd=5 at cycle 4. hazard=0 in cycle 4 (bypass); pending[5]=0 at cycle 5.
- Full: MAX_OUTSTANDING=4; issue to x1..x4; long-latency to x6 → hazard=1, outstanding=4. Completion x2 same cycle → issue allowed, outstanding stays 4, pending={1,3,4,6}.
- WAW plus flush: x7 pending, ID rd=x7 → stall. Same scenario with flush=1 → hazard=0, pending unchanged.
- Fence: outstanding=2, fence_id=1 → stall. One completion → still stall. Second completion cycle → hazard=0.
- Error/x0: cpl_rd=0 → no change, cpl_err=0. cpl_rd=9 not pending → cpl_err=1, stays 1 until rst_n low asynchronously clears it.

Source files
------------

// File: rtl/core_pkg.sv
// Shared integer-core types and sizing constants used by the register scoreboard.
package core_pkg;
  localparam int NREG                = 32;
  localparam int REG_IDX_W           = 5;
  localparam int MAX_OUTSTANDING_DEF = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Width needed to hold 0..max_out in-flight writes.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING_DEF);
endpackage

// File: rtl/sb_decode.sv
// 5-to-NREG one-hot decoder; x0 never produces a bit since it is never tracked.
module sb_decode import core_pkg::*; #(
  parameter int NREG = core_pkg::NREG
) (
  input  logic [4:0]      idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i && idx_i != 5'd0) onehot_o[idx_i] = 1'b1;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for variable-latency integer writers; drives the ID
// stall outputs and tracks in-flight count with a same-cycle completion bypass.
module reg_scoreboard import core_pkg::*; #(
  parameter  int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter  int NREG            = core_pkg::NREG,
  localparam int CW              = cnt_width(MAX_OUTSTANDING)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic [4:0]      rd_id,
  input  logic            long_lat_id,
  input  logic            fence_id,
  input  logic            flush,
  input  logic            cpl_valid,
  input  logic [4:0]      cpl_rd,
  output logic            ifid_write,
  output logic            pcwrite,
  output logic            hazard,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   outstanding,
  output logic            cpl_err
);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic            cpl_err_q, cpl_err_d;

  logic [NREG-1:0] set_mask, clr_mask, eff;
  logic            raw, waw, full, fence_wait, stall, issue;
  logic            cpl_hit, trk_cpl, err_evt;

  sb_decode #(.NREG(NREG)) u_dec_cpl (
    .idx_i(cpl_rd), .en_i(cpl_valid), .onehot_o(clr_mask)
  );
  sb_decode #(.NREG(NREG)) u_dec_rd (
    .idx_i(rd_id), .en_i(issue), .onehot_o(set_mask)
  );

  // Completion bypass: a write finishing this cycle no longer blocks ID.
  assign eff = pending_q & ~clr_mask;

  assign raw = (use_rs1 && rs1_id != 5'd0 && eff[rs1_id]) ||
               (use_rs2 && rs2_id != 5'd0 && eff[rs2_id]);
  assign waw = rd_id != 5'd0 && eff[rd_id];
  assign full = long_lat_id && rd_id != 5'd0 && outstanding_q == MAX_CNT && !cpl_valid;
  assign fence_wait = fence_id && (outstanding_q != {{(CW-1){1'b0}}, cpl_valid});

  assign stall = id_valid && !flush && (raw || waw || full || fence_wait);
  assign issue = id_valid && !flush && !stall && long_lat_id && rd_id != 5'd0;

  assign hazard     = stall;
  assign ifid_write = !stall;
  assign pcwrite    = !stall;

  assign cpl_hit = cpl_valid && cpl_rd != 5'd0;
  assign trk_cpl = cpl_hit && pending_q[cpl_rd];
  assign err_evt = cpl_hit && !pending_q[cpl_rd];

  // Set after clear so a bypassed re-issue to the same register stays pending.
  assign pending_d = (pending_q & ~clr_mask) | set_mask;
  assign cpl_err_d = cpl_err_q || err_evt;

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !trk_cpl)      outstanding_d = outstanding_q + CW'(1);
    else if (!issue && trk_cpl) outstanding_d = outstanding_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      cpl_err_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      cpl_err_q     <= cpl_err_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign cpl_err     = cpl_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic checked every cycle against a set/count model of the scoreboard.
module tb_reg_scoreboard;
  import core_pkg::*;
  localparam int MAXO = 4;
  localparam int CW   = cnt_width(MAXO);

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, use_rs1, use_rs2, long_lat_id, fence_id, flush, cpl_valid;
  logic [4:0] rs1_id, rs2_id, rd_id, cpl_rd;
  logic ifid_write, pcwrite, hazard, cpl_err;
  logic [31:0] pending;
  logic [CW-1:0] outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: set of registers awaiting a write, an in-flight count, an error flag.
  bit mp[32];
  int mcnt;
  bit merr;

  reg_scoreboard #(.MAX_OUTSTANDING(MAXO), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_id(rd_id), .long_lat_id(long_lat_id),
    .fence_id(fence_id), .flush(flush), .cpl_valid(cpl_valid), .cpl_rd(cpl_rd),
    .ifid_write(ifid_write), .pcwrite(pcwrite), .hazard(hazard), .pending(pending),
    .outstanding(outstanding), .cpl_err(cpl_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit blocked(input int r);
    return r != 0 && mp[r] && !(cpl_valid && int'(cpl_rd) == r);
  endfunction

  function automatic bit m_stall();
    bit raw, waw, full, fw;
    raw  = (use_rs1 && blocked(int'(rs1_id))) || (use_rs2 && blocked(int'(rs2_id)));
    waw  = blocked(int'(rd_id));
    full = long_lat_id && rd_id != 0 && mcnt == MAXO && !cpl_valid;
    fw   = fence_id && (mcnt - int'(cpl_valid)) != 0;
    return id_valid && !flush && (raw || waw || full || fw);
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mp[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) mp[i] = 0;
    mcnt = 0;
    merr = 0;
  endtask

  task automatic m_cmp();
    bit s;
    if (!rst_n) m_clear();
    s = m_stall();
    chk("hazard", hazard, s);
    chk("ifid_write", ifid_write, !s);
    chk("pcwrite", pcwrite, !s);
    chk("pending", pending, m_vec());
    chk("outstanding", outstanding, mcnt);
    chk("cpl_err", cpl_err, merr);
    chk("inv_popcount", outstanding, $countones(pending));
  endtask

  task automatic m_apply();
    bit s, iss, trk, err;
    if (!rst_n) begin m_clear(); return; end
    s   = m_stall();
    iss = id_valid && !flush && !s && long_lat_id && rd_id != 0;
    trk = cpl_valid && cpl_rd != 0 && mp[cpl_rd];
    err = cpl_valid && cpl_rd != 0 && !mp[cpl_rd];
    if (trk) mp[cpl_rd] = 0;
    if (iss) mp[rd_id] = 1;
    mcnt = mcnt + int'(iss) - int'(trk);
    if (err) merr = 1;
  endtask

  task automatic drv(input bit iv, input int r1, input bit u1, input int r2, input bit u2,
                     input int rd, input bit ll, input bit fe, input bit fl,
                     input bit cv, input int crd);
    id_valid = iv; rs1_id = 5'(r1); use_rs1 = u1; rs2_id = 5'(r2); use_rs2 = u2;
    rd_id = 5'(rd); long_lat_id = ll; fence_id = fe; flush = fl;
    cpl_valid = cv; cpl_rd = 5'(crd);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    #1;
    m_cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    m_apply();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    settle();
    adv();
    rst_n = 1'b1;
  endtask

  initial begin
    m_clear();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    settle();
    adv();
    rst_n = 1'b1;

    // Reset then idle
    idle(); settle();
    chk("rst_ifid", ifid_write, 1); chk("rst_pcwrite", pcwrite, 1);
    chk("rst_hazard", hazard, 0); chk("rst_pending", pending, 0);
    chk("rst_outstanding", outstanding, 0);
    adv();

    // RAW with completion bypass
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); settle(); chk("raw_issue", hazard, 0); adv();
    for (int c = 1; c <= 3; c++) begin
      drv(1, 5, 1, 0, 0, 10, 0, 0, 0, 0, 0); settle(); chk("raw_stall", hazard, 1); adv();
    end
    drv(1, 5, 1, 0, 0, 10, 0, 0, 0, 1, 5); settle(); chk("raw_bypass", hazard, 0); adv();
    idle(); settle(); chk("raw_cleared", pending[5], 0); chk("raw_cnt", outstanding, 0); adv();

    // Full
    for (int r = 1; r <= 4; r++) begin
      drv(1, 0, 0, 0, 0, r, 1, 0, 0, 0, 0); settle(); adv();
    end
    drv(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0); settle();
    chk("full_stall", hazard, 1); chk("full_cnt", outstanding, 4); adv();
    drv(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 2); settle(); chk("full_bypass", hazard, 0); adv();
    idle(); settle(); chk("full_cnt_after", outstanding, 4); chk("full_pending", pending, 32'h5A);
    adv();
    do_reset();

    // WAW and flush
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); settle(); adv();
    drv(1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0); settle(); chk("waw_stall", hazard, 1); adv();
    drv(1, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0); settle();
    chk("flush_hazard", hazard, 0); chk("flush_ifid", ifid_write, 1); adv();
    drv(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0); settle(); adv();
    idle(); settle(); chk("flush_pending", pending, 32'h80); adv();

    // Fence
    drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); settle(); adv();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); settle(); chk("fence_cnt", outstanding, 2);
    chk("fence_stall2", hazard, 1); adv();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7); settle(); chk("fence_stall1", hazard, 1); adv();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8); settle(); chk("fence_release", hazard, 0); adv();
    idle(); settle(); chk("fence_empty", outstanding, 0); adv();

    // x0 completion and stray completion error
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); settle(); adv();
    idle(); settle(); chk("x0_err", cpl_err, 0); chk("x0_cnt", outstanding, 0); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); settle(); adv();
    idle(); settle(); chk("err_set", cpl_err, 1); adv(); adv();
    settle(); chk("err_sticky", cpl_err, 1);
    rst_n = 1'b0; #1;
    chk("err_async_clr", cpl_err, 0);
    settle(); adv();
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int q[$];
      int crd;
      bit cv;
      q.delete();
      for (int r = 1; r < 32; r++) if (mp[r]) q.push_back(r);
      cv = 0; crd = 0;
      if ($urandom_range(0, 99) < 35) begin
        if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
          cv = 1; crd = q[$urandom_range(0, q.size() - 1)];
        end else if (mcnt < MAXO) begin
          cv = 1; crd = $urandom_range(0, 31);
        end
      end
      drv($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          cv, crd);
      if (i == 700) rst_n = 1'b0;
      if (i == 702) rst_n = 1'b1;
      settle();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
